// File: rtl/line_delay_sched.sv
// line_delay_sched: ring-buffer sequencer giving a fixed DELAY_LINES line latency
// between captured DE lines and RAM reads, with a synthetic flush after the last line.
module line_delay_sched #(
  parameter int H_ACTIVE     = 800,
  parameter int V_ACTIVE     = 480,
  parameter int DELAY_LINES  = 3,
  parameter int FLUSH_HBLANK = 127,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              vsync_in,
  input  logic              de_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              de_out,
  output logic [9:0]        line_cnt,
  output logic [2:0]        state,
  output logic              frame_done,
  output logic              line_err
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam int DEPTH = H_ACTIVE * (DELAY_LINES + 1);
  localparam int PW    = $clog2(H_ACTIVE + 2);
  localparam int FW    = $clog2(FLUSH_HBLANK + H_ACTIVE);
  localparam int LW    = (DELAY_LINES > 1) ? $clog2(DELAY_LINES) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [PW-1:0]     PIX_FULL   = PW'(H_ACTIVE);
  localparam logic [PW-1:0]     PIX_SAT    = PW'(H_ACTIVE + 1);
  localparam logic [FW-1:0]     F_RD       = FW'(FLUSH_HBLANK);
  localparam logic [FW-1:0]     F_LAST     = FW'(FLUSH_HBLANK + H_ACTIVE - 1);
  localparam logic [LW-1:0]     FL_LAST    = LW'(DELAY_LINES - 1);
  localparam logic [9:0]        CNT_STREAM = 10'(DELAY_LINES);
  localparam logic [9:0]        CNT_FLUSH  = 10'(V_ACTIVE);
  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_de_out;
  logic [9:0]        r_line_cnt;
  logic              r_frame_done;
  logic              r_line_err;
  logic              r_de_prev;
  logic [PW-1:0]     r_pix_cnt;
  logic [FW-1:0]     r_fcnt;
  logic [LW-1:0]     r_flines;
  logic              w_run;
  logic              w_capture;
  logic              w_line_end;
  logic              w_fline_end;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [9:0]        w_cnt_next;
  logic [ADDR_W-1:0] w_wr_next;
  logic [ADDR_W-1:0] w_rd_next;
  always_comb begin
    w_run       = rst_n & vsync_in & enable;
    w_capture   = (r_state == S_IDLE) | (r_state == S_FILL) | (r_state == S_STREAM);
    w_line_end  = ~de_in & r_de_prev & ((r_state == S_FILL) | (r_state == S_STREAM));
    w_fline_end = (r_fcnt == F_LAST);
    w_wr_en     = w_run & de_in & w_capture;
    w_rd_en     = w_run & (((r_state == S_STREAM) & de_in) | ((r_state == S_FLUSH) & (r_fcnt >= F_RD)));
    w_cnt_next  = (r_line_cnt == 10'd1023) ? r_line_cnt : r_line_cnt + 10'd1;
    w_wr_next   = (r_wr_addr == ADDR_LAST) ? '0 : r_wr_addr + 1'b1;
    w_rd_next   = (r_rd_addr == ADDR_LAST) ? '0 : r_rd_addr + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_de_out     <= 1'b0;
      r_line_cnt   <= '0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
      r_de_prev    <= 1'b0;
      r_pix_cnt    <= '0;
      r_fcnt       <= '0;
      r_flines     <= '0;
    end else begin
      r_de_out     <= w_rd_en;
      r_frame_done <= 1'b0;
      if (!vsync_in || !enable) begin
        r_state    <= S_IDLE;
        r_wr_addr  <= '0;
        r_rd_addr  <= '0;
        r_line_cnt <= '0;
        r_de_prev  <= 1'b0;
        r_pix_cnt  <= '0;
        r_fcnt     <= '0;
        r_flines   <= '0;
        if (!vsync_in) r_line_err <= 1'b0;
      end else begin
        r_de_prev <= de_in;
        if (w_wr_en) r_wr_addr <= w_wr_next;
        if (w_rd_en) r_rd_addr <= w_rd_next;
        if (r_state == S_FLUSH && de_in) r_line_err <= 1'b1;
        // Line length is only flagged, never used to realign the ring addresses
        if (w_line_end) begin
          r_pix_cnt  <= '0;
          r_line_cnt <= w_cnt_next;
          if (r_pix_cnt != PIX_FULL) r_line_err <= 1'b1;
        end else if (w_wr_en && r_pix_cnt != PIX_SAT) begin
          r_pix_cnt <= r_pix_cnt + 1'b1;
        end
        case (r_state)
          S_IDLE:   if (de_in) r_state <= S_FILL;
          S_FILL:   if (w_line_end && w_cnt_next == CNT_STREAM) r_state <= S_STREAM;
          S_STREAM: if (w_line_end && w_cnt_next == CNT_FLUSH) begin
            r_state  <= S_FLUSH;
            r_fcnt   <= '0;
            r_flines <= '0;
          end
          S_FLUSH: begin
            r_fcnt <= w_fline_end ? '0 : r_fcnt + 1'b1;
            if (w_fline_end) begin
              r_flines <= r_flines + 1'b1;
              if (r_flines == FL_LAST) begin
                r_state      <= S_DONE;
                r_frame_done <= 1'b1;
              end
            end
          end
          S_DONE:  r_state <= S_DONE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
  assign wr_en      = w_wr_en;
  assign rd_en      = w_rd_en;
  assign wr_addr    = r_wr_addr;
  assign rd_addr    = r_rd_addr;
  assign de_out     = r_de_out;
  assign line_cnt   = r_line_cnt;
  assign state      = r_state;
  assign frame_done = r_frame_done;
  assign line_err   = r_line_err;
endmodule

// File: tb/tb_line_delay_sched.sv
// tb_line_delay_sched: directed bench for line_delay_sched with H=8, V=6, D=3, HBLANK=4.
module tb_line_delay_sched;
  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       vsync_in;
  logic       de_in;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic       de_out;
  logic [9:0] line_cnt;
  logic [2:0] state;
  logic       frame_done;
  logic       line_err;
  int n_cmp = 0;
  int n_bad = 0;
  line_delay_sched #(
    .H_ACTIVE(8), .V_ACTIVE(6), .DELAY_LINES(3), .FLUSH_HBLANK(4), .ADDR_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .vsync_in(vsync_in), .de_in(de_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr), .de_out(de_out),
    .line_cnt(line_cnt), .state(state), .frame_done(frame_done), .line_err(line_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Inputs change just after a rising edge; outputs are sampled at the following falling edge.
  task automatic tick(input logic r, input logic v, input logic e, input logic d);
    @(posedge clk);
    #1;
    rst_n = r; vsync_in = v; enable = e; de_in = d;
    @(negedge clk);
  endtask
  task automatic px(input logic d);
    tick(1'b1, 1'b1, 1'b1, d);
  endtask
  task automatic frame_start();
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic run_lines(input int n);
    for (int l = 0; l < n; l++)
      for (int p = 0; p < 12; p++) px(p < 8);
  endtask
  task automatic test_reset();
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got=%0d exp=0", wr_en); end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_cmp++; if (wr_addr !== 6'd0 || rd_addr !== 6'd0) begin n_bad++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", wr_addr, rd_addr); end
    n_cmp++; if (line_cnt !== 10'd0) begin n_bad++; $display("FAIL reset_line_cnt got=%0d exp=0", line_cnt); end
    n_cmp++; if ({rd_en, de_out, frame_done, line_err} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got=%b exp=0000", {rd_en, de_out, frame_done, line_err}); end
  endtask
  task automatic test_full_frame();
    int wcnt = 0;
    int rcnt = 0;
    int fd = 0;
    logic prev_rd = 1'b0;
    frame_start();
    for (int l = 0; l < 6; l++) begin
      for (int p = 0; p < 12; p++) begin
        px(p < 8);
        if (l == 0 && p == 1) begin n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL ff_fill_state got=%0d exp=1", state); end end
        if (l == 3 && p == 0) begin n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL ff_stream_state got=%0d exp=2", state); end end
        if (l == 4 && p == 0) begin n_cmp++; if (wr_addr !== 6'd0) begin n_bad++; $display("FAIL ff_wr_wrap got=%0d exp=0", wr_addr); end end
        n_cmp++; if (wr_en !== (p < 8)) begin n_bad++; $display("FAIL ff_wr_en l=%0d p=%0d got=%0d exp=%0d", l, p, wr_en, p < 8); end
        n_cmp++; if (rd_en !== (p < 8 && l >= 3)) begin n_bad++; $display("FAIL ff_rd_en l=%0d p=%0d got=%0d exp=%0d", l, p, rd_en, p < 8 && l >= 3); end
        n_cmp++; if (de_out !== prev_rd) begin n_bad++; $display("FAIL ff_de_out l=%0d p=%0d got=%0d exp=%0d", l, p, de_out, prev_rd); end
        if (wr_en === 1'b1) begin
          n_cmp++; if (wr_addr !== 6'(wcnt % 32)) begin n_bad++; $display("FAIL ff_wr_addr got=%0d exp=%0d", wr_addr, wcnt % 32); end
          wcnt++;
        end
        if (rd_en === 1'b1) begin
          n_cmp++; if (rd_addr !== 6'(rcnt % 32)) begin n_bad++; $display("FAIL ff_rd_addr got=%0d exp=%0d", rd_addr, rcnt % 32); end
          rcnt++;
        end
        prev_rd = rd_en;
      end
    end
    for (int j = 3; j < 40; j++) begin
      px(1'b0);
      if (j == 3) begin n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL ff_flush_state got=%0d exp=3", state); end end
      if (j == 12) begin n_cmp++; if (rd_addr !== 6'd0) begin n_bad++; $display("FAIL ff_rd_wrap got=%0d exp=0", rd_addr); end end
      if (j < 36) begin n_cmp++; if (rd_en !== ((j % 12) >= 4)) begin n_bad++; $display("FAIL ff_flush_rd_en j=%0d got=%0d exp=%0d", j, rd_en, (j % 12) >= 4); end end
      n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL ff_flush_wr_en j=%0d got=%0d exp=0", j, wr_en); end
      n_cmp++; if (de_out !== prev_rd) begin n_bad++; $display("FAIL ff_flush_de_out j=%0d got=%0d exp=%0d", j, de_out, prev_rd); end
      if (rd_en === 1'b1) begin
        n_cmp++; if (rd_addr !== 6'(rcnt % 32)) begin n_bad++; $display("FAIL ff_flush_rd_addr got=%0d exp=%0d", rd_addr, rcnt % 32); end
        rcnt++;
      end
      if (frame_done === 1'b1) fd++;
      prev_rd = rd_en;
    end
    n_cmp++; if (rcnt != 48) begin n_bad++; $display("FAIL ff_reads got=%0d exp=48", rcnt); end
    n_cmp++; if (wcnt != 48) begin n_bad++; $display("FAIL ff_writes got=%0d exp=48", wcnt); end
    n_cmp++; if (fd != 1) begin n_bad++; $display("FAIL ff_frame_done_pulses got=%0d exp=1", fd); end
    n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL ff_done_state got=%0d exp=4", state); end
    n_cmp++; if (line_cnt !== 10'd6) begin n_bad++; $display("FAIL ff_line_cnt got=%0d exp=6", line_cnt); end
    n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL ff_line_err got=%0d exp=0", line_err); end
  endtask
  task automatic test_bad_line();
    frame_start();
    for (int l = 0; l < 5; l++) begin
      for (int p = 0; p < ((l == 2) ? 7 : 8); p++) px(1'b1);
      for (int g = 0; g < 4; g++) begin
        px(1'b0);
        if ((l == 1 && g == 1) || (l == 2 && g == 0)) begin
          n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL bad_err_early l=%0d g=%0d got=%0d exp=0", l, g, line_err); end
        end
        if ((l == 2 && g == 1) || (l == 4 && g == 3)) begin
          n_cmp++; if (line_err !== 1'b1) begin n_bad++; $display("FAIL bad_err_set l=%0d g=%0d got=%0d exp=1", l, g, line_err); end
        end
      end
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (line_err !== 1'b1) begin n_bad++; $display("FAIL bad_err_held got=%0d exp=1", line_err); end
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL bad_err_cleared got=%0d exp=0", line_err); end
  endtask
  task automatic test_vsync_mid();
    frame_start();
    run_lines(3);
    for (int p = 0; p < 3; p++) px(1'b1);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL vs_stream got=%0d exp=2", state); end
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    n_cmp++; if ({wr_en, rd_en} !== 2'b00) begin n_bad++; $display("FAIL vs_strobes got=%b exp=00", {wr_en, rd_en}); end
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL vs_idle got=%0d exp=0", state); end
    n_cmp++; if (wr_addr !== 6'd0 || rd_addr !== 6'd0) begin n_bad++; $display("FAIL vs_addr got=%0d/%0d exp=0/0", wr_addr, rd_addr); end
    n_cmp++; if (line_cnt !== 10'd0) begin n_bad++; $display("FAIL vs_line_cnt got=%0d exp=0", line_cnt); end
    px(1'b1);
    n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 6'd0) begin n_bad++; $display("FAIL vs_restart_wr got=%0d@%0d exp=1@0", wr_en, wr_addr); end
    px(1'b1);
    n_cmp++; if (state !== 3'd1 || wr_addr !== 6'd1) begin n_bad++; $display("FAIL vs_restart_fill got=%0d@%0d exp=1@1", state, wr_addr); end
  endtask
  task automatic test_flush_de();
    int rcnt = 0;
    frame_start();
    run_lines(6);
    for (int j = 3; j < 37; j++) begin
      px(j == 5 || j == 14);
      if (j == 5) begin n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL fd_err_before got=%0d exp=0", line_err); end end
      if (j == 6) begin n_cmp++; if (line_err !== 1'b1) begin n_bad++; $display("FAIL fd_err_set got=%0d exp=1", line_err); end end
      if (j < 36) begin
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL fd_wr_en j=%0d got=%0d exp=0", j, wr_en); end
        n_cmp++; if (rd_en !== ((j % 12) >= 4)) begin n_bad++; $display("FAIL fd_rd_en j=%0d got=%0d exp=%0d", j, rd_en, (j % 12) >= 4); end
      end
      if (rd_en === 1'b1) begin
        n_cmp++; if (rd_addr !== 6'((24 + rcnt) % 32)) begin n_bad++; $display("FAIL fd_rd_addr got=%0d exp=%0d", rd_addr, (24 + rcnt) % 32); end
        rcnt++;
      end
    end
    n_cmp++; if (rcnt != 24) begin n_bad++; $display("FAIL fd_reads got=%0d exp=24", rcnt); end
    n_cmp++; if (state !== 3'd4 || frame_done !== 1'b1) begin n_bad++; $display("FAIL fd_done got=%0d/%0d exp=4/1", state, frame_done); end
  endtask
  task automatic test_enable_rst();
    frame_start();
    run_lines(1);
    for (int p = 0; p < 3; p++) px(1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if ({wr_en, rd_en} !== 2'b00) begin n_bad++; $display("FAIL en_strobes got=%b exp=00", {wr_en, rd_en}); end
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (state !== 3'd0 || wr_addr !== 6'd0 || line_cnt !== 10'd0) begin n_bad++; $display("FAIL en_idle got=%0d/%0d/%0d exp=0/0/0", state, wr_addr, line_cnt); end
    frame_start();
    run_lines(6);
    px(1'b1);
    repeat (33) px(1'b0);
    n_cmp++; if (state !== 3'd4 || line_err !== 1'b1) begin n_bad++; $display("FAIL en_done got=%0d/%0d exp=4/1", state, line_err); end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    n_cmp++; if (wr_addr !== 6'd0 || rd_addr !== 6'd0 || line_cnt !== 10'd0) begin n_bad++; $display("FAIL rst_counts got=%0d/%0d/%0d exp=0/0/0", wr_addr, rd_addr, line_cnt); end
    n_cmp++; if ({wr_en, rd_en, de_out, frame_done, line_err} !== 5'b0) begin n_bad++; $display("FAIL rst_flags got=%b exp=00000", {wr_en, rd_en, de_out, frame_done, line_err}); end
  endtask
  initial begin
    rst_n = 1'b0; enable = 1'b1; vsync_in = 1'b1; de_in = 1'b0;
    test_reset();
    test_full_frame();
    test_bad_line();
    test_vsync_mid();
    test_flush_de();
    test_enable_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
